// File: rtl/dm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dm_pkg : shared size codes, FSM states and helpers for dm_pipe_mem       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package dm_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Reserved size reports 4 so the range check stays conservative; it errors anyway.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_load_fmt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dm_load_fmt : little-endian load formatter with sign/zero extension      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module dm_load_fmt
  import dm_pkg::*;
(
  input  logic [7:0]  i_b0,
  input  logic [7:0]  i_b1,
  input  logic [7:0]  i_b2,
  input  logic [7:0]  i_b3,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = '0;
    case (i_size)
      SZ_B:    o_data = {{24{i_signed & i_b0[7]}}, i_b0};
      SZ_H:    o_data = {{16{i_signed & i_b1[7]}}, i_b1, i_b0};
      SZ_W:    o_data = {i_b3, i_b2, i_b1, i_b0};
      default: o_data = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dm_pipe_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dm_pipe_mem : byte-addressable data memory, valid/ready req, LAT-cycle rsp|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module dm_pipe_mem
  import dm_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_signed,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [ADDR_W:0]  c_DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] c_CNT_LOAD  = CNT_W'(LAT - 1);

  logic [7:0]       r_mem [DEPTH];
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      r_rsp_rdata;
  logic             r_rsp_err;

  logic             w_accept;
  logic             w_misalign;
  logic             w_range;
  logic             w_err;
  logic             w_store;
  logic [ADDR_W:0]  w_end;
  logic [IDX_W-1:0] w_idx  [4];
  logic [7:0]       w_byte [4];
  logic [31:0]      w_load;

  // Lanes past the end of storage are parked on index 0; such requests always error.
  generate
    for (genvar k = 0; k < 4; k++) begin : g_lane
      logic [ADDR_W:0] w_sum;
      assign w_sum     = {1'b0, i_req_addr} + (ADDR_W + 1)'(k);
      assign w_idx[k]  = (w_sum < c_DEPTH_EXT) ? w_sum[IDX_W-1:0] : '0;
      assign w_byte[k] = r_mem[w_idx[k]];
    end
  endgenerate

  assign o_req_ready = (r_state == IDLE) || ((r_state == RESP) && i_rsp_ready);
  assign w_accept    = i_req_valid && o_req_ready && !rst;

  assign w_misalign = ((i_req_size == SZ_H) && i_req_addr[0]) ||
                      ((i_req_size == SZ_W) && (i_req_addr[1:0] != 2'b00));
  assign w_end      = {1'b0, i_req_addr} + (ADDR_W + 1)'(size_bytes(i_req_size));
  assign w_range    = (w_end > c_DEPTH_EXT);
  assign w_err      = (i_req_size == SZ_R) || w_misalign || w_range;
  assign w_store    = w_accept && i_req_we && !w_err;

  // Storage is deliberately left out of reset so committed stores survive it.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[w_idx[0]] <= i_req_wdata[7:0];
      if (i_req_size != SZ_B) begin
        r_mem[w_idx[1]] <= i_req_wdata[15:8];
      end
      if (i_req_size == SZ_W) begin
        r_mem[w_idx[2]] <= i_req_wdata[23:16];
        r_mem[w_idx[3]] <= i_req_wdata[31:24];
      end
    end
  end

  dm_load_fmt u_fmt (
    .i_b0     (w_byte[0]),
    .i_b1     (w_byte[1]),
    .i_b2     (w_byte[2]),
    .i_b3     (w_byte[3]),
    .i_size   (i_req_size),
    .i_signed (i_req_signed),
    .o_data   (w_load)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: ;
      WAIT: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // A new accept in RESP overrides the return to IDLE, retiring the old response.
    if (w_accept) begin
      w_state_nxt = (LAT > 1) ? WAIT : RESP;
      w_cnt_nxt   = c_CNT_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_rsp_err   <= w_err;
        r_rsp_rdata <= (i_req_we || w_err) ? '0 : w_load;
      end
    end
  end

  assign o_rsp_valid = (r_state == RESP);
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

endmodule
`default_nettype wire
